// File: rtl/lcd_fb_dma.sv
// lcd_fb_dma: frame-copy DMA from the LCD GDRAM (96x64 1bpp, FB_BYTES bytes)
// into the back bank of a double-buffered display framebuffer.
//
// A start pulse copies the whole GDRAM into the bank that is not being
// scanned out. The banks are swapped during vertical blank, so scanout never
// shows a torn frame.
//
// Ports:
//   clk, reset      system clock, synchronous active-high reset
//   start           one-cycle frame-complete pulse, requests a copy
//   vblank          scanout vertical blank level
//   cpu_req         CPU owns the source port this cycle (DMA yields)
//   src_rd/addr     DMA read strobe/address on the source port
//   src_data        source read data, valid one cycle after src_rd
//   dst_we/addr/data framebuffer write port, dst_addr = {bank, byte}
//   display_bank    bank currently scanned out
//   busy            high from accepted start until the bank swap
//   overrun_count   saturating count of starts dropped while busy
//   dbg_state_o     current FSM state (IDLE=0, COPY=1, DRAIN=2, WAIT_SWAP=3)
//
// Source-port arbitration: cpu_req has absolute priority. src_rd is
// combinational and never high in a cycle with cpu_req=1. A yielded cycle is a
// pure stall, because the read counter holds. The destination port is
// private, so writes never stall.
module lcd_fb_dma #(
  parameter int FB_BYTES = 768,
  parameter int ADDR_W   = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              vblank,
  input  logic              cpu_req,
  output logic              src_rd,
  output logic [ADDR_W-1:0] src_addr,
  input  logic [7:0]        src_data,
  output logic              dst_we,
  output logic [ADDR_W:0]   dst_addr,
  output logic [7:0]        dst_data,
  output logic              display_bank,
  output logic              busy,
  output logic [7:0]        overrun_count,
  output logic [1:0]        dbg_state_o
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    COPY      = 2'd1,
    DRAIN     = 2'd2,
    WAIT_SWAP = 2'd3
  } state_e;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_BYTES - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              back_q, back_d;
  logic              disp_q, disp_d;
  logic [7:0]        ovr_q, ovr_d;
  // A write is pending for the read issued in the previous cycle.
  logic              pend_q;
  logic [ADDR_W:0]   waddr_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    back_d  = back_q;
    disp_d  = disp_q;
    ovr_d   = ovr_q;
    src_rd  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = COPY;
          cnt_d   = '0;
          back_d  = ~disp_q;
        end
      end
      COPY: begin
        if (!cpu_req) begin
          src_rd = 1'b1;
          if (cnt_q == LAST_ADDR) begin
            // The counter parks at 0, so it never goes past the last byte.
            cnt_d   = '0;
            state_d = DRAIN;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        state_d = WAIT_SWAP;
      end
      WAIT_SWAP: begin
        if (vblank) begin
          disp_d  = ~disp_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Any start outside IDLE is dropped. This includes the swap cycle itself.
    if (start && (state_q != IDLE) && (ovr_q != 8'hFF)) begin
      ovr_d = ovr_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      back_q  <= 1'b0;
      disp_q  <= 1'b0;
      ovr_q   <= '0;
      pend_q  <= 1'b0;
      waddr_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      back_q  <= back_d;
      disp_q  <= disp_d;
      ovr_q   <= ovr_d;
      pend_q  <= src_rd;
      if (src_rd) begin
        waddr_q <= {back_q, cnt_q};
      end
    end
  end

  assign src_addr      = cnt_q;
  assign dst_we        = pend_q;
  assign dst_addr      = waddr_q;
  // The source data arrives in the write cycle and is passed straight through.
  // It is gated, so the write data is 0 whenever no write is in progress.
  assign dst_data      = pend_q ? src_data : 8'd0;
  assign display_bank  = disp_q;
  assign busy          = (state_q != IDLE);
  assign overrun_count = ovr_q;
  assign dbg_state_o   = state_q;

endmodule

// File: doc/lcd_fb_dma.md
Name: lcd_fb_dma

Overview:
- Frame-copy controller between the LCD GDRAM (source RAM, 96x64 1bpp, 768 bytes) and a double-buffered display framebuffer read by video scanout.
- On each frame-complete pulse it copies the whole GDRAM into the back framebuffer bank, yielding the shared source port to the CPU whenever the CPU requests it.
- After the copy completes, it swaps banks during vertical blank, so scanout never shows a torn frame.

Parameters:
- FB_BYTES, 768, bytes per frame copied (96 columns x 8 pages).
- ADDR_W, 10, width of the source/destination byte address.

Ports:
- clk, input, 1, system clock.
- reset, input, 1, synchronous active-high reset.
- start, input, 1, one-cycle frame-complete pulse that requests a copy.
- vblank, input, 1, scanout vertical blank (level, synchronous to clk).
- cpu_req, input, 1, CPU owns the source RAM port this cycle.
- src_rd, output, 1, DMA read strobe on the source port.
- src_addr, output, ADDR_W, source read address.
- src_data, input, 8, source read data, valid 1 cycle after src_rd.
- dst_we, output, 1, framebuffer write strobe.
- dst_addr, output, ADDR_W+1, {bank, byte address} write address.
- dst_data, output, 8, framebuffer write data.
- display_bank, output, 1, bank currently scanned out.
- busy, output, 1, high from accepted start until the bank swap.
- overrun_count, output, 8, saturating count of starts dropped while busy.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous, active-high.
- Reset values: state IDLE; src_rd=0, src_addr=0, dst_we=0, dst_addr=0, dst_data=0, display_bank=0, busy=0, overrun_count=0, read counter=0, pending flag=0.
- Reset mid-copy aborts the copy. No dst_we is asserted after the reset edge. display_bank is forced to 0.
- States: IDLE, COPY, DRAIN, WAIT_SWAP.
- IDLE:
  - start=1 -> COPY; busy=1 on the next cycle; read counter=0; back bank latched as ~display_bank.
- COPY:
  - Each cycle with cpu_req=0: src_rd=1 and src_addr=counter; counter increments.
  - Each cycle with cpu_req=1: src_rd=0 and the counter holds. This is a stall with no lost bytes.
  - When the read at address FB_BYTES-1 issues -> DRAIN.
- Write pipeline (runs in every state):
  - If src_rd was 1 in cycle t, then in cycle t+1: dst_we=1, dst_addr={back bank, address issued at t}, dst_data=src_data.
  - The destination port is private, so a write never stalls, even when cpu_req=1 in cycle t+1.
- DRAIN: one cycle for the final write -> WAIT_SWAP.
- WAIT_SWAP:
  - On the first cycle with vblank=1: display_bank toggles, busy=0 -> IDLE.
  - If vblank is already high on entry, the swap happens that same cycle.
- Throughput and latency:
  - Unstalled, the first write lands 1 cycle after the first read; the last write lands FB_BYTES cycles after the first read.
  - Total start-to-IDLE time is FB_BYTES+2 cycles plus stall cycles plus vblank wait.
- start while busy=1 (any non-IDLE state): the pulse is ignored and overrun_count increments, saturating at 255.
- start in the same cycle as the WAIT_SWAP->IDLE transition counts as overrun, because busy is still 1.
- Address wrap: the counter never exceeds FB_BYTES-1. The DMA never reads an address >= FB_BYTES.
- dst_we is never asserted to display_bank while busy=1. Scanout reads of display_bank are therefore coherent.

Test Plan:
- Reset, preload source[i]=i[7:0], start pulse, cpu_req=0, vblank=0 -> 768 consecutive dst_we with dst_addr={1,i}, dst_data=i[7:0], first write 2 cycles after start. busy=1 and display_bank=0 until vblank. Raise vblank -> display_bank=1 next cycle, busy=0.
- Copy with cpu_req=1 every odd cycle -> 768 writes total, no address skipped or duplicated, src_rd never high while cpu_req=1; completion takes ~1536 cycles.
- Second start after the first swap (display_bank=1) -> writes target bank 0 (dst_addr[10]=0); after vblank display_bank=0.
- 3 start pulses during COPY and 1 in WAIT_SWAP -> overrun_count=4, copy unaffected. 300 extra pulses -> overrun_count=255.
- Assert reset at byte 400 of a copy -> no dst_we after the reset edge, display_bank=0, busy=0, overrun_count=0. A fresh start completes a normal 768-byte copy to bank 1.
- vblank held high throughout the copy -> swap occurs in the first WAIT_SWAP cycle, i.e. 1 cycle after DRAIN.
